regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port reg_write  input  1  write enable.
REQ-008 SHALL have port write_reg  input  AW  write index.
REQ-009 SHALL have port write_data  input  XLEN  write value.
REQ-010 SHALL have port read_reg  input  NRD*AW  packed read indices, port i at [i*AW +: AW].
REQ-011 SHALL have port read_data  output  NRD*XLEN  packed read values, port i at [i*XLEN +: XLEN].
REQ-012 SHALL have port busy_set  input  1  mark busy_reg as pending writeback.
REQ-013 SHALL have port busy_reg  input  AW  index to mark.
REQ-014 SHALL have port read_busy  output  NRD  pending flag per read port.
REQ-015 SHALL have port ready  output  1  high once clear sequence is complete.

Function
REQ-016 SHALL implement FSM states CLEAR and RUN; rst forces CLEAR with clear_idx=0.
REQ-017 SHALL, in CLEAR with rst low, write 0 to reg[clear_idx] each cycle and increment clear_idx; after index NREG-1 is written, go to RUN next cycle.
REQ-018 SHALL drive ready=1 only in RUN; ready rises exactly NREG cycles after the first cycle with rst low.
REQ-019 SHALL ignore reg_write and busy_set in CLEAR, and drive all read_data=0 and read_busy=0 in CLEAR.
REQ-020 SHALL, in RUN, write write_data to reg[write_reg] at the clock edge when reg_write=1 and write_reg!=0.
REQ-021 SHALL read combinationally (zero latency): read_data[i] = reg[read_reg[i]]; index 0 always returns 0.
REQ-022 SHALL, when BYPASS=1, RUN, reg_write=1, write_reg!=0 and read_reg[i]==write_reg, return write_data on port i in the same cycle; when BYPASS=0, return the old value.
REQ-023 SHALL keep one busy bit per register; busy_set in RUN sets bit busy_reg at the edge; reg_write clears bit write_reg at the edge.
REQ-024 SHALL, when busy_set and reg_write target the same index in one cycle, leave the bit set (set wins).
REQ-025 SHALL never set busy bit 0; busy_set or reg_write with index 0 has no effect.
REQ-026 SHALL drive read_busy[i] = busy[read_reg[i]], forced 0 when BYPASS=1 and the same-cycle forwarding of REQ-022 applies without a same-index busy_set.
REQ-027 SHALL serve all NRD ports independently, including several ports reading the same index.

Reset
REQ-028 SHALL, while rst=1, hold ready=0, state CLEAR, clear_idx=0, all busy bits 0; register contents are cleared by the CLEAR sweep, not by rst itself.
REQ-029 SHALL restart the full sweep if rst is asserted mid-CLEAR or in RUN, discarding any write in that cycle.

Structure
REQ-030 SHALL take the state enum (CLEAR, RUN) and the index-width helper function from shared package regfile_pkg.
REQ-031 SHALL place the busy-bit array and its set/clear/priority logic in sub-module regfile_scoreboard.

Verification
REQ-032 SHALL check: rst 3 cycles then release, NREG=32 -> ready=0 for 32 cycles, ready=1 on cycle 33, every register reads 0.
REQ-033 SHALL check: RUN, write x5=0xDEADBEEF with read_reg0=5, BYPASS=1 -> read_data0=0xDEADBEEF same cycle; BYPASS=0 -> old value, then 0xDEADBEEF next cycle.
REQ-034 SHALL check: write x0=0x1234 -> all ports reading x0 return 0, busy bit 0 unchanged.
REQ-035 SHALL check: busy_set x7, next cycle read_busy=1 on port reading 7; reg_write x7 -> read_busy=0 following cycle; simultaneous busy_set x7 and reg_write x7 -> read_busy stays 1.
REQ-036 SHALL check: x9=0x55 in RUN, assert rst 1 cycle -> writes/busy_set ignored for 32 cycles, x9 reads 0 after ready.
REQ-037 SHALL check: NRD=4, all ports read x3=0xA5A5A5A5 -> all four read_data equal 0xA5A5A5A5.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register file: sequencer states and index sizing.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Index width for a register count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read, busy-tracking and ready signals of the multi-port register file.
interface regfile_mp_if
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    import regfile_pkg::*;

    localparam int AW = idx_width(NREG);

    logic                reg_write;
    logic [AW-1:0]       write_reg;
    logic [XLEN-1:0]     write_data;
    logic [NRD*AW-1:0]   read_reg;
    logic [NRD*XLEN-1:0] read_data;
    logic                busy_set;
    logic [AW-1:0]       busy_reg;
    logic [NRD-1:0]      read_busy;
    logic                ready;

    modport master (
        output reg_write, write_reg, write_data, read_reg, busy_set, busy_reg,
        input  read_data, read_busy, ready
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg, busy_set, busy_reg,
        output read_data, read_busy, ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// One pending-writeback bit per register; a set and a clear of the same index in one cycle leaves it set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = idx_width(NREG)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    output logic [NREG-1:0] busy
);

    // The set is applied after the clear so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en && clr_idx != '0)
                busy[clr_idx] <= 1'b0;
            if (set_en && set_idx != '0)
                busy[set_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clear sweep, optional write forwarding and busy tracking.
//   state | meaning
//   CLEAR | sweeping zeros into every register, bus ignored, outputs held at 0
//   RUN   | normal read/write/busy operation, ready high
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
)
(
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int AW = idx_width(NREG);

    state_t              state;
    logic [AW-1:0]       clear_idx;
    logic                ready;
    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     busy;
    logic                run;
    logic                wr_en;
    logic                set_en;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    assign run    = (state == RUN);
    assign wr_en  = run && bus.reg_write && (bus.write_reg != '0);
    assign set_en = run && bus.busy_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clear_idx <= '0;
            ready     <= 1'b0;
        end else if (state == CLEAR) begin
            clear_idx <= clear_idx + 1'b1;
            if (clear_idx == AW'(NREG - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                regs[clear_idx] <= '0;
            else if (wr_en)
                regs[bus.write_reg] <= bus.write_data;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_idx (bus.busy_reg),
        .clr_en  (wr_en),
        .clr_idx (bus.write_reg),
        .busy    (busy)
    );

    always_comb begin
        logic [AW-1:0] idx;
        logic          fwd;
        rd_data = '0;
        rd_busy = '0;
        idx     = '0;
        fwd     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            idx = bus.read_reg[i*AW +: AW];
            fwd = (BYPASS != 0) && wr_en && (idx == bus.write_reg);
            if (run && idx != '0) begin
                rd_data[i*XLEN +: XLEN] = fwd ? bus.write_data : regs[idx];
                // A forwarded write retires the pending flag unless it is being re-marked now.
                rd_busy[i] = busy[idx] && !(fwd && !(bus.busy_set && bus.busy_reg == idx));
            end
        end
    end

    assign bus.read_data = rd_data;
    assign bus.read_busy = rd_busy;
    assign bus.ready     = ready;

endmodule
